// File: rtl/hangman_pkg.sv
// Shared types and limits for the two-player hangman round controller.
package hangman_pkg;

    typedef enum logic [3:0] {
        S_WIPE,
        S_LOAD,
        S_GALLOWS,
        S_DASHES,
        S_GUESS,
        S_COMPARE,
        S_EVAL,
        S_FILL,
        S_PART,
        S_OVER
    } state_t;

    localparam logic [4:0] MAX_WORD_LEN = 5'd16;
    localparam logic [2:0] MAX_PARTS    = 3'd6;
    localparam logic [3:0] SCORE_MAX    = 4'd9;

    typedef struct packed {
        logic wipe;
        logic ld_g;
        logic dash;
        logic fill;
        logic draw;
        logic compare;
        logic timecount;
        logic round_over;
    } ctl_t;

    localparam ctl_t CTL_RESET = ctl_t'(8'h80);

endpackage

// File: rtl/hangman_control_score.sv
// Saturating 4-bit round-win counter; cleared only by reset.
module score_counter
    import hangman_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       i_inc,
    output logic [3:0] o_count
);

    logic [3:0] r_count;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_count <= '0;
        end else if (i_inc && (r_count != SCORE_MAX)) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hangman_control.sv
// Round sequencing FSM for hangman: word entry, drawing, guessing, scoring.
module hangman_control
    import hangman_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       key_enter,
    input  logic       key_done,
    input  logic       key_guess,
    input  logic       draw_done,
    input  logic       match,
    input  logic       remain_zero,
    input  logic       timeout,
    output logic       wipe,
    output logic       ld_g,
    output logic       dash,
    output logic       fill,
    output logic       draw,
    output logic       ld,
    output logic       compare,
    output logic       timecount,
    output logic [2:0] part,
    output logic [4:0] word_len,
    output logic [3:0] p1score,
    output logic [3:0] p2score,
    output logic       round_over
);

    state_t     r_state;
    state_t     w_next;
    ctl_t       r_ctl;
    ctl_t       w_ctl;
    logic       r_ld;
    logic [4:0] r_word_len;
    logic [2:0] r_miss;
    logic [2:0] r_part;
    logic       r_win;
    logic [4:0] w_cnt;
    logic [2:0] w_miss_inc;
    logic       w_load_ok;
    logic       w_p1_win;
    logic       w_p2_win;

    // A letter strobed last cycle is counted before word_len catches up.
    assign w_cnt      = r_word_len + {4'd0, r_ld};
    assign w_miss_inc = r_miss + 3'd1;
    assign w_load_ok  = (r_state == S_LOAD) && key_enter
                        && (w_cnt < MAX_WORD_LEN);
    assign w_p1_win   = ((r_state == S_GUESS) && timeout)
                        || ((r_state == S_PART) && draw_done
                            && (w_miss_inc == MAX_PARTS));
    assign w_p2_win   = (r_state == S_FILL) && draw_done && r_win;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_state <= S_WIPE;
            r_ctl   <= CTL_RESET;
        end else begin
            r_state <= w_next;
            r_ctl   <= w_ctl;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_WIPE:    if (draw_done) w_next = S_LOAD;
            S_LOAD:    if (key_done && !key_enter && (w_cnt != 5'd0))
                           w_next = S_GALLOWS;
            S_GALLOWS: if (draw_done) w_next = S_DASHES;
            S_DASHES:  if (draw_done) w_next = S_GUESS;
            S_GUESS:   if (timeout) w_next = S_OVER;
                       else if (key_guess) w_next = S_COMPARE;
            S_COMPARE: w_next = S_EVAL;
            S_EVAL:    w_next = match ? S_FILL : S_PART;
            S_FILL:    if (draw_done) w_next = r_win ? S_OVER : S_GUESS;
            S_PART:    if (draw_done)
                           w_next = (w_miss_inc == MAX_PARTS) ? S_OVER : S_GUESS;
            S_OVER:    if (key_enter) w_next = S_WIPE;
            default:   w_next = S_WIPE;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        w_ctl = '0;
        unique case (w_next)
            S_WIPE:    w_ctl.wipe       = 1'b1;
            S_GALLOWS: w_ctl.ld_g       = 1'b1;
            S_DASHES:  w_ctl.dash       = 1'b1;
            S_GUESS:   w_ctl.timecount  = 1'b1;
            S_COMPARE: w_ctl.compare    = 1'b1;
            S_FILL:    w_ctl.fill       = 1'b1;
            S_PART:    w_ctl.draw       = 1'b1;
            S_OVER:    w_ctl.round_over = 1'b1;
            default:   w_ctl = '0;
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            r_ld       <= 1'b0;
            r_word_len <= '0;
            r_miss     <= '0;
            r_part     <= '0;
            r_win      <= 1'b0;
        end else begin
            r_ld <= w_load_ok;
            if (r_state == S_WIPE) begin
                r_word_len <= '0;
                r_miss     <= '0;
                r_part     <= '0;
            end else begin
                if (r_ld)
                    r_word_len <= r_word_len + 5'd1;
                if ((r_state == S_PART) && draw_done)
                    r_miss <= w_miss_inc;
                if ((r_state == S_EVAL) && !match)
                    r_part <= r_miss;
            end
            if (r_state == S_EVAL)
                r_win <= remain_zero;
        end
    end

    score_counter u_p1 (
        .clk     (clk),
        .resetn  (resetn),
        .i_inc   (w_p1_win),
        .o_count (p1score)
    );

    score_counter u_p2 (
        .clk     (clk),
        .resetn  (resetn),
        .i_inc   (w_p2_win),
        .o_count (p2score)
    );

    assign wipe       = r_ctl.wipe;
    assign ld_g       = r_ctl.ld_g;
    assign dash       = r_ctl.dash;
    assign fill       = r_ctl.fill;
    assign draw       = r_ctl.draw;
    assign compare    = r_ctl.compare;
    assign timecount  = r_ctl.timecount;
    assign round_over = r_ctl.round_over;
    assign ld         = r_ld;
    assign part       = r_part;
    assign word_len   = r_word_len;

endmodule

// File: tb/tb_hangman_control.sv
// Randomized round-level bench for hangman_control with a score/word model.
module tb_hangman_control;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       key_enter = 1'b0;
    logic       key_done = 1'b0;
    logic       key_guess = 1'b0;
    logic       draw_done = 1'b0;
    logic       match = 1'b0;
    logic       remain_zero = 1'b0;
    logic       timeout = 1'b0;
    logic       wipe, ld_g, dash, fill, draw, ld, compare, timecount;
    logic [2:0] part;
    logic [4:0] word_len;
    logic [3:0] p1score, p2score;
    logic       round_over;

    int total = 0;
    int bad = 0;
    int ld_cnt = 0;
    int cmp_cnt = 0;
    int p1_exp = 0;
    int p2_exp = 0;

    localparam int PH_WIPE = 0, PH_LOAD = 1, PH_GALLOWS = 2, PH_DASHES = 3;
    localparam int PH_GUESS = 4, PH_COMPARE = 5, PH_FILL = 7, PH_PART = 8;
    localparam int PH_OVER = 9, PH_BAD = 15;
    localparam int P_ENTER = 0, P_DONE = 1, P_GUESS = 2, P_DRAW = 3;

    hangman_control dut (
        .clk         (clk),
        .resetn      (resetn),
        .key_enter   (key_enter),
        .key_done    (key_done),
        .key_guess   (key_guess),
        .draw_done   (draw_done),
        .match       (match),
        .remain_zero (remain_zero),
        .timeout     (timeout),
        .wipe        (wipe),
        .ld_g        (ld_g),
        .dash        (dash),
        .fill        (fill),
        .draw        (draw),
        .ld          (ld),
        .compare     (compare),
        .timecount   (timecount),
        .part        (part),
        .word_len    (word_len),
        .p1score     (p1score),
        .p2score     (p2score),
        .round_over  (round_over)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ld) ld_cnt++;
        if (compare) cmp_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Which round phase the enable outputs currently announce.
    function automatic int phase();
        logic [7:0] v;
        v = {wipe, ld_g, dash, timecount, compare, fill, draw, round_over};
        if ($countones(v) > 1) return PH_BAD;
        if (wipe) return PH_WIPE;
        if (ld_g) return PH_GALLOWS;
        if (dash) return PH_DASHES;
        if (timecount) return PH_GUESS;
        if (compare) return PH_COMPARE;
        if (fill) return PH_FILL;
        if (draw) return PH_PART;
        if (round_over) return PH_OVER;
        return PH_LOAD;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int which);
        case (which)
            P_ENTER: key_enter = 1'b1;
            P_DONE:  key_done  = 1'b1;
            P_GUESS: key_guess = 1'b1;
            default: draw_done = 1'b1;
        endcase
        tick();
        key_enter = 1'b0;
        key_done  = 1'b0;
        key_guess = 1'b0;
        draw_done = 1'b0;
    endtask

    function automatic int sat9(input int v);
        return (v >= 9) ? 9 : v + 1;
    endfunction

    // mode: 0 random, 1 p2 wins at once, 2 six misses,
    //       3 timeout together with guess, 4 reset while drawing a part
    task automatic play_round(input int nlet, input int mode);
        int n_exp, ld0, miss, guesses, c0;
        bit done, hit, rz;
        chk("wipe_start", phase(), PH_WIPE);
        pulse(P_DRAW);
        chk("to_load", phase(), PH_LOAD);
        ld0 = ld_cnt;
        for (int i = 0; i < nlet; i++) begin
            pulse(P_ENTER);
            tick($urandom_range(0, 2));
        end
        n_exp = (nlet > 16) ? 16 : nlet;
        if (mode == 0 && nlet > 0 && nlet < 16) begin
            key_enter = 1'b1;
            key_done = 1'b1;
            tick();
            key_enter = 1'b0;
            key_done = 1'b0;
            n_exp++;
            chk("enter_done_stay", phase(), PH_LOAD);
        end
        tick(2);
        chk("ld_pulses", ld_cnt - ld0, n_exp);
        chk("word_len", word_len, n_exp);
        if (n_exp == 0) begin
            pulse(P_DONE);
            tick();
            chk("done_empty", phase(), PH_LOAD);
            pulse(P_ENTER);
            tick(2);
            chk("word_len_one", word_len, 1);
        end
        pulse(P_DONE);
        chk("to_gallows", phase(), PH_GALLOWS);
        key_guess = 1'b1;
        timeout = 1'b1;
        tick();
        key_guess = 1'b0;
        timeout = 1'b0;
        chk("gallows_hold", phase(), PH_GALLOWS);
        pulse(P_DRAW);
        chk("to_dashes", phase(), PH_DASHES);
        pulse(P_DRAW);
        chk("to_guess", phase(), PH_GUESS);
        miss = 0;
        done = 0;
        guesses = 0;
        while (!done) begin
            guesses++;
            if (mode == 0 && $urandom_range(0, 3) == 0) begin
                pulse($urandom_range(0, 1) ? P_DRAW : P_ENTER);
                chk("guess_ignore", phase(), PH_GUESS);
            end
            if (mode == 3 || (mode == 0 &&
                ($urandom_range(0, 9) == 0 || guesses > 30))) begin
                c0 = cmp_cnt;
                timeout = 1'b1;
                key_guess = (mode == 3) ? 1'b1 : 1'($urandom_range(0, 1));
                tick();
                timeout = 1'b0;
                key_guess = 1'b0;
                p1_exp = sat9(p1_exp);
                chk("timeout_over", phase(), PH_OVER);
                tick();
                chk("timeout_no_cmp", cmp_cnt - c0, 0);
                done = 1;
            end else begin
                hit = (mode == 1) ? 1'b1 :
                      (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
                rz  = (mode == 1) ? 1'b1 :
                      (mode == 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
                pulse(P_GUESS);
                chk("compare_on", compare, 1);
                match = hit;
                remain_zero = rz;
                tick();
                chk("compare_off", compare, 0);
                tick();
                match = 1'($urandom_range(0, 1));
                remain_zero = 1'($urandom_range(0, 1));
                if (hit) begin
                    chk("to_fill", phase(), PH_FILL);
                    pulse(P_DRAW);
                    if (rz) begin
                        p2_exp = sat9(p2_exp);
                        chk("fill_over", phase(), PH_OVER);
                        done = 1;
                    end else begin
                        chk("fill_guess", phase(), PH_GUESS);
                    end
                end else begin
                    chk("to_part", phase(), PH_PART);
                    chk("part_idx", part, miss);
                    if (mode == 4) begin
                        resetn = 1'b1;
                        #1;
                        p1_exp = 0;
                        p2_exp = 0;
                        chk("rst_wipe", wipe, 1);
                        chk("rst_draw", draw, 0);
                        chk("rst_part", part, 0);
                        chk("rst_p1", p1score, p1_exp);
                        chk("rst_p2", p2score, p2_exp);
                        tick();
                        resetn = 1'b0;
                        match = 1'b0;
                        tick();
                        return;
                    end
                    pulse(P_DRAW);
                    miss++;
                    if (miss == 6) begin
                        p1_exp = sat9(p1_exp);
                        chk("part_over", phase(), PH_OVER);
                        done = 1;
                    end else begin
                        chk("part_guess", phase(), PH_GUESS);
                    end
                end
            end
        end
        match = 1'b0;
        chk("p1score", p1score, p1_exp);
        chk("p2score", p2score, p2_exp);
        pulse(P_DRAW);
        chk("over_hold", phase(), PH_OVER);
        pulse(P_ENTER);
        chk("to_wipe", phase(), PH_WIPE);
    endtask

    initial begin
        tick(3);
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        chk("rst_phase", phase(), PH_WIPE);
        chk("rst_ld", ld, 0);
        chk("rst_len", word_len, 0);
        chk("rst_part0", part, 0);
        chk("rst_p1_0", p1score, 0);
        chk("rst_p2_0", p2score, 0);
        resetn = 1'b0;
        tick();
        chk("post_rst", phase(), PH_WIPE);

        play_round(3, 2);
        play_round(17, 1);
        play_round(0, 0);
        play_round(4, 3);
        play_round(5, 0);
        for (int r = 0; r < 10; r++)
            play_round($urandom_range(1, 5), 1);
        chk("p2_saturated", p2score, 9);
        for (int r = 0; r < 12; r++)
            play_round($urandom_range(0, 18), 0);
        play_round(2, 4);
        play_round(2, 1);
        play_round(1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hangman_control.md
HANGMAN_CONTROL -- requirements
Module: hangman_control

Interface
REQ-001 The block SHALL use clock clk and reset resetn, which is asynchronous and active-high.
REQ-002 clk  in  1  system clock; all state changes on its rising edge.
REQ-003 resetn  in  1  asynchronous, active-high reset.
REQ-004 key_enter  in  1  one-cycle pulse; player 1 letter strobe, or the next-round request in OVER.
REQ-005 key_done  in  1  one-cycle pulse; player 1 has finished entering the word.
REQ-006 key_guess  in  1  one-cycle pulse; player 2 has submitted a guess letter.
REQ-007 draw_done  in  1  one-cycle pulse from the active draw engine when its figure is complete.
REQ-008 match, remain_zero  in  1 each  datapath compare results; valid the cycle after compare.
REQ-009 timeout  in  1  level from the guess timer.
REQ-010 wipe, ld_g, dash, fill, draw  out  1 each  draw-engine enables; each held high for the whole of its state.
REQ-011 ld  out  1  one-cycle write strobe for a letter into word memory.
REQ-012 compare  out  1  one-cycle compare strobe.
REQ-013 timecount  out  1  timer enable; high only in GUESS.
REQ-014 part  out  3  index of the body part being drawn, 0..5 (head, body, left arm, right arm, left leg, right leg).
REQ-015 word_len  out  5  number of letters loaded, 0..16.
REQ-016 p1score, p2score  out  4 each  round-win counts, BCD range 0..9.
REQ-017 round_over  out  1  high in state OVER.

Function
REQ-018 The FSM states SHALL be WIPE, LOAD, GALLOWS, DASHES, GUESS, COMPARE, EVAL, FILL, PART and OVER.
REQ-019 WIPE SHALL assert wipe, clear word_len and the mistake count, and go to LOAD on draw_done.
REQ-020 In LOAD, key_enter with word_len<16 SHALL pulse ld for one cycle and then increment word_len; key_enter with word_len=16 SHALL be ignored.
REQ-021 In LOAD, key_done with word_len>0 SHALL go to GALLOWS; key_done with word_len=0 SHALL be ignored.
REQ-022 If key_enter and key_done arrive in the same cycle in LOAD, the letter SHALL be loaded and the FSM SHALL stay in LOAD.
REQ-023 GALLOWS SHALL assert ld_g and go to DASHES on draw_done.
REQ-024 DASHES SHALL assert dash and go to GUESS on draw_done.
REQ-025 In GUESS, timeout SHALL take priority over key_guess: award p1 and go to OVER; otherwise key_guess SHALL go to COMPARE.
REQ-026 COMPARE SHALL last exactly one cycle with compare=1 and then go to EVAL.
REQ-027 EVAL SHALL last one cycle: match=1 goes to FILL; match=0 goes to PART with part equal to the current mistake count.
REQ-028 FILL SHALL go on draw_done to OVER with p2 awarded if remain_zero (as sampled in EVAL) is 1, and otherwise back to GUESS.
REQ-029 PART SHALL increment the mistake count on draw_done; if the new count is 6 it SHALL award p1 and go to OVER, otherwise back to GUESS.
REQ-030 Scores SHALL saturate at 9, SHALL persist across rounds, and SHALL be cleared only by reset.
REQ-031 OVER SHALL assert round_over and go to WIPE on key_enter.
REQ-032 draw_done, key and timeout inputs arriving in states that do not consume them SHALL be ignored.
REQ-033 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-034 While resetn=1, the state SHALL be WIPE and all outputs and counters SHALL be 0, except wipe=1.
REQ-035 A reset asserted mid-round SHALL abort the round immediately and clear the scores.

Structure
REQ-036 A shared package SHALL hold the state enumeration, MAX_WORD_LEN=16, MAX_PARTS=6 and SCORE_MAX=9.
REQ-037 The score logic SHALL be one sub-module, score_counter (4-bit saturating incrementer), instantiated twice.

Verification
REQ-038 Reset, one draw_done, 3 key_enter, key_done -> three ld pulses, word_len=3, FSM in GALLOWS.
REQ-039 17 key_enter in LOAD -> exactly 16 ld pulses, word_len=16; key_done at word_len=0 -> FSM stays in LOAD.
REQ-040 Six guesses with match=0 -> part sequence 0,1,2,3,4,5, then OVER with p1score=1.
REQ-041 Guess with match=1 and remain_zero=1 -> FILL, then OVER with p2score=1; with remain_zero=0 -> back to GUESS.
REQ-042 timeout and key_guess in the same GUESS cycle -> no compare pulse, p1score increments, FSM in OVER.
REQ-043 Ten p2 wins -> p2score=9; a reset during PART -> FSM in WIPE and both scores 0.
